// File: rtl/fm_morse_tx.sv
// Single-clock FM transmitter with Morse keyer: element queue in, keyed NCO carrier out.
// During marks the carrier increment is deviated by a registered sine test tone.
module fm_morse_tx #(
    parameter real         CLK_HZ          = 240_000_000.0,
    parameter real         CARRIER_HZ      = 106_500_000.0,
    parameter real         TONE_HZ         = 750.0,
    parameter int unsigned UNIT_CYCLES     = 21_600_000,
    parameter int unsigned RF_PHASE_BITS   = 32,
    parameter int unsigned TONE_PHASE_BITS = 24,
    parameter int unsigned LUT_BITS        = 6,
    parameter int unsigned SIN_BITS        = 16,
    parameter int unsigned DEV_SHIFT       = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     symValid,
    input  logic [1:0]               sym,
    output logic                     symReady,
    output logic                     keyOn,
    output logic                     busy,
    output logic [RF_PHASE_BITS-1:0] dPhase,
    output logic                     rf
);

    // Truncating real->integer conversion (the cast alone rounds to nearest).
    localparam real    CarrierIncR = (2.0 ** RF_PHASE_BITS) * CARRIER_HZ / CLK_HZ;
    localparam longint CarrierIncL = longint'(CarrierIncR);
    localparam logic [RF_PHASE_BITS-1:0] CarrierInc = RF_PHASE_BITS'(
        (real'(CarrierIncL) > CarrierIncR) ? CarrierIncL - 1 : CarrierIncL);

    localparam real    ToneIncR = (2.0 ** TONE_PHASE_BITS) * TONE_HZ / CLK_HZ;
    localparam longint ToneIncL = longint'(ToneIncR);
    localparam logic [TONE_PHASE_BITS-1:0] ToneInc = TONE_PHASE_BITS'(
        (real'(ToneIncL) > ToneIncR) ? ToneIncL - 1 : ToneIncL);

    localparam int unsigned CntW    = $clog2(6 * UNIT_CYCLES) + 1;
    localparam int unsigned LutSize = 1 << LUT_BITS;

    localparam logic [CntW-1:0] Load1 = CntW'(UNIT_CYCLES - 1);
    localparam logic [CntW-1:0] Load2 = CntW'(2 * UNIT_CYCLES - 1);
    localparam logic [CntW-1:0] Load3 = CntW'(3 * UNIT_CYCLES - 1);
    localparam logic [CntW-1:0] Load6 = CntW'(6 * UNIT_CYCLES - 1);

    typedef logic [LutSize-1:0][SIN_BITS-1:0] lut_t;

    function automatic lut_t buildLut();
        lut_t tbl;
        real  amp;
        real  ang;
        amp = (2.0 ** (SIN_BITS - 1)) - 1.0;
        for (int unsigned i = 0; i < LutSize; i++) begin
            ang    = 2.0 * 3.141592653589793 * real'(i) / real'(LutSize);
            tbl[i] = SIN_BITS'(longint'(amp * $sin(ang)));
        end
        return tbl;
    endfunction

    localparam lut_t SineLut = buildLut();

    typedef enum logic [1:0] {StIdle, StMark, StSpace} state_e;

    state_e                       stateQ, stateD;
    logic [CntW-1:0]              cntQ, cntD;
    logic                         toneClear;
    logic                         symReadyQ;
    logic [TONE_PHASE_BITS-1:0]   tonePhaseQ;
    logic signed [SIN_BITS-1:0]   sineQ;
    logic [RF_PHASE_BITS-1:0]     dPhaseQ, dPhaseD;
    logic [RF_PHASE_BITS-1:0]     rfPhaseQ;
    logic                         rfQ;
    logic signed [RF_PHASE_BITS-1:0] sineExt;
    logic [LUT_BITS-1:0]          lutIdx;

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        toneClear = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (symValid && symReadyQ) begin
                    toneClear = ~sym[1];
                    case (sym)
                        2'd0:    begin stateD = StMark;  cntD = Load1; end
                        2'd1:    begin stateD = StMark;  cntD = Load3; end
                        2'd2:    begin stateD = StSpace; cntD = Load2; end
                        default: begin stateD = StSpace; cntD = Load6; end
                    endcase
                end
            end
            StMark: begin
                if (cntQ == '0) begin
                    stateD = StSpace;
                    cntD   = Load1;
                end else begin
                    cntD = cntQ - 1'b1;
                end
            end
            StSpace: begin
                if (cntQ == '0) begin
                    stateD = StIdle;
                end else begin
                    cntD = cntQ - 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign keyOn   = (stateQ == StMark);
    assign busy    = (stateQ != StIdle);
    assign lutIdx  = tonePhaseQ[TONE_PHASE_BITS-1 -: LUT_BITS];
    assign sineExt = RF_PHASE_BITS'(sineQ);

    always_comb begin
        dPhaseD = CarrierInc;
        if (keyOn) begin
            dPhaseD = CarrierInc + RF_PHASE_BITS'(sineExt <<< DEV_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= StIdle;
            cntQ       <= '0;
            symReadyQ  <= 1'b0;
            tonePhaseQ <= '0;
            sineQ      <= '0;
            dPhaseQ    <= CarrierInc;
            rfPhaseQ   <= '0;
            rfQ        <= 1'b0;
        end else begin
            stateQ     <= stateD;
            cntQ       <= cntD;
            symReadyQ  <= (stateD == StIdle);
            tonePhaseQ <= toneClear ? '0 : tonePhaseQ + ToneInc;
            sineQ      <= SineLut[lutIdx];
            dPhaseQ    <= dPhaseD;
            rfPhaseQ   <= rfPhaseQ + dPhaseQ;
            rfQ        <= rfPhaseQ[RF_PHASE_BITS-1];
        end
    end

    assign symReady = symReadyQ;
    assign dPhase   = dPhaseQ;
    assign rf       = rfQ;

endmodule
